// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer between the UART receiver and the processor's
//   memory-mapped I/O. Each byte flagged by the receiver is captured once,
//   acknowledged with a single-cycle rxClear pulse and queued in a circular
//   FIFO that the processor drains at its own pace (first-word-fall-through).
//
// Optional feature macro: UART_RX_FIFO_OVERRUN_EN
//   When defined, a sticky overrun flag (with its clear input) records that a
//   byte arrived while the FIFO was full and had to be dropped. When
//   undefined, such bytes are still dropped, silently.
//
// Ports
//   clock_50MHZ  in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   rxReady      in   receiver has a byte on rxDataOut
//   rxDataOut    in   [7:0] received byte
//   rxClear      out  one-cycle acknowledge back to the receiver
//   rd_en        in   pop request (ignored when empty)
//   rd_data      out  [7:0] head byte, 8'h00 when empty
//   empty        out  FIFO holds no entries
//   full         out  FIFO holds DEPTH entries
//   count        out  [AW:0] occupancy 0..DEPTH
//   overrun      out  sticky dropped-byte flag      (macro only)
//   overrun_clr  in   clears overrun, set wins      (macro only)

module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock_50MHZ,
    input  logic          reset,
    input  logic          rxReady,
    input  logic [7:0]    rxDataOut,
    output logic          rxClear,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
`ifdef UART_RX_FIFO_OVERRUN_EN
    output logic          overrun,
    input  logic          overrun_clr,
`endif
    output logic [AW:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    state_t         state;
    state_t         state_next;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    logic           push_req;
    logic           push_ok;
    logic           pop;

    // Capture FSM: state register
    always_ff @(posedge clock_50MHZ) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture FSM: next state and acknowledge. S_WAIT holds until the
    // receiver has dropped rxReady so a lingering flag is never re-captured.
    always_comb begin
        state_next = state;
        rxClear    = 1'b0;
        push_req   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rxReady) begin
                    push_req   = 1'b1;
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                rxClear    = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!rxReady) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A full FIFO can still accept a byte when a pop frees a slot this cycle.
    assign pop     = rd_en && !empty;
    assign push_ok = push_req && (!full || rd_en);

    // Storage is not reset; only pointers and occupancy are.
    always_ff @(posedge clock_50MHZ) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= rxDataOut;
        end
    end

    always_ff @(posedge clock_50MHZ) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

`ifdef UART_RX_FIFO_OVERRUN_EN
    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clock_50MHZ) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (push_req && !push_ok) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo: reset state, single capture with held
//   rxReady, fill/drain with pointer wrap, drop when full, simultaneous
//   push/pop, pop on empty and reset during an acknowledge. Overrun flag
//   checks are compiled only with UART_RX_FIFO_OVERRUN_EN.

module tb_uart_rx_fifo;

    logic        clk;
    logic        reset;
    logic        rxReady;
    logic [7:0]  rxDataOut;
    logic        rxClear;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  count;
`ifdef UART_RX_FIFO_OVERRUN_EN
    logic        overrun;
    logic        overrun_clr;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clock_50MHZ (clk),
        .reset       (reset),
        .rxReady     (rxReady),
        .rxDataOut   (rxDataOut),
        .rxClear     (rxClear),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
`ifdef UART_RX_FIFO_OVERRUN_EN
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
`endif
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full receiver handshake: capture, acknowledge cycle, back to idle.
    task automatic push_byte(input logic [7:0] b);
        rxReady   = 1'b1;
        rxDataOut = b;
        tick();
        rxReady = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [16];

        reset     = 1'b1;
        rxReady   = 1'b0;
        rxDataOut = 8'h00;
        rd_en     = 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
        overrun_clr = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_rxClear", 32'(rxClear), 32'd0);
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_empty",   32'(empty),   32'd1);
        chk("rst_full",    32'(full),    32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
`ifdef UART_RX_FIFO_OVERRUN_EN
        chk("rst_overrun", 32'(overrun), 32'd0);
`endif

        // Single byte, rxReady held for 5 cycles
        rxReady   = 1'b1;
        rxDataOut = 8'hA5;
        tick();
        chk("one_count",   32'(count),   32'd1);
        chk("one_empty",   32'(empty),   32'd0);
        chk("one_rd_data", 32'(rd_data), 32'hA5);
        chk("one_clr_hi",  32'(rxClear), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_clr_lo", 32'(rxClear), 32'd0);
            chk("hold_count",  32'(count),   32'd1);
        end
        rxReady = 1'b0;
        tick();
        tick();
        pop_one();
        chk("one_pop_empty", 32'(empty),   32'd1);
        chk("one_pop_data",  32'(rd_data), 32'h00);

        // Fill and drain twice; second pass wraps both pointers
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) push_byte(8'(pass * 16 + i));
            chk("fill_full",  32'(full),  32'd1);
            chk("fill_count", 32'(count), 32'd16);
            for (int i = 0; i < 16; i++) begin
                chk("drain_data", 32'(rd_data), 32'(pass * 16 + i));
                pop_one();
            end
            chk("drain_empty", 32'(empty),   32'd1);
            chk("drain_zero",  32'(rd_data), 32'h00);
        end

        // Drop while full
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        rxReady   = 1'b1;
        rxDataOut = 8'hEE;
        tick();
        chk("ovr_count", 32'(count),   32'd16);
        chk("ovr_head",  32'(rd_data), 32'h00);
`ifdef UART_RX_FIFO_OVERRUN_EN
        chk("ovr_set", 32'(overrun), 32'd1);
`endif
        rxReady = 1'b0;
        tick();
        tick();
`ifdef UART_RX_FIFO_OVERRUN_EN
        chk("ovr_sticky", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        // Drop and clear in the same cycle: set wins
        rxReady     = 1'b1;
        rxDataOut   = 8'hEF;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        rxReady     = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        tick();
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
`endif

        // Full with push and pop in the same cycle: accepted
        rxReady   = 1'b1;
        rxDataOut = 8'h77;
        rd_en     = 1'b1;
        tick();
        rd_en   = 1'b0;
        rxReady = 1'b0;
        chk("fullpp_count", 32'(count),   32'd16);
        chk("fullpp_head",  32'(rd_data), 32'h01);
`ifdef UART_RX_FIFO_OVERRUN_EN
        chk("fullpp_no_ovr", 32'(overrun), 32'd0);
`endif
        tick();
        tick();
        for (int i = 0; i < 15; i++) exp_q[i] = 8'(i + 1);
        exp_q[15] = 8'h77;
        for (int i = 0; i < 16; i++) begin
            chk("fullpp_drain", 32'(rd_data), 32'(exp_q[i]));
            pop_one();
        end
        chk("fullpp_empty", 32'(empty), 32'd1);

        // Push and pop at count 3
        push_byte(8'h30);
        push_byte(8'h31);
        push_byte(8'h32);
        rxReady   = 1'b1;
        rxDataOut = 8'h33;
        rd_en     = 1'b1;
        tick();
        rd_en   = 1'b0;
        rxReady = 1'b0;
        chk("mid_pp_count", 32'(count),   32'd3);
        chk("mid_pp_head",  32'(rd_data), 32'h31);
        tick();
        tick();
        exp_q[0] = 8'h31;
        exp_q[1] = 8'h32;
        exp_q[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            chk("mid_pp_drain", 32'(rd_data), 32'(exp_q[i]));
            pop_one();
        end

        // Push and pop on empty: pop ignored
        rxReady   = 1'b1;
        rxDataOut = 8'h44;
        rd_en     = 1'b1;
        tick();
        rd_en   = 1'b0;
        rxReady = 1'b0;
        chk("empty_pp_count", 32'(count),   32'd1);
        chk("empty_pp_data",  32'(rd_data), 32'h44);
        tick();
        tick();
        pop_one();

        // Pop on empty for 4 cycles
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rd_en = 1'b0;
        chk("pope_count", 32'(count),   32'd0);
        chk("pope_empty", 32'(empty),   32'd1);
        chk("pope_data",  32'(rd_data), 32'h00);
        push_byte(8'h55);
        chk("pope_ptrs", 32'(rd_data), 32'h55);
        pop_one();

        // Reset during the acknowledge cycle with count 5
        for (int i = 0; i < 4; i++) push_byte(8'(8'h60 + i));
        rxReady   = 1'b1;
        rxDataOut = 8'h64;
        tick();
        chk("mr_count_pre", 32'(count),   32'd5);
        chk("mr_clr_pre",   32'(rxClear), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_rxClear", 32'(rxClear), 32'd0);
        chk("mr_count",   32'(count),   32'd0);
        chk("mr_empty",   32'(empty),   32'd1);
        tick();
        chk("mr_recap_count", 32'(count),   32'd1);
        chk("mr_recap_data",  32'(rd_data), 32'h64);
        chk("mr_recap_clr",   32'(rxClear), 32'd1);
        rxReady = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
